gf_mul_by_0xe: RTL and testbench

GF_MUL_BY_0XE -- requirements
Module: gf_mul_by_0xe

---
 rtl/gf_pkg.sv | 25 ++
 rtl/gf_mul_by_0xe_if.sv | 25 ++
 rtl/gf_xtime.sv | 12 +
 rtl/gf_mul_by_0xe.sv | 85 ++++++++
 tb/tb_gf_mul_by_0xe.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/gf_pkg.sv
// Shared GF(2^8) definitions: the AES field, its reduction constant,
// the byte type and the InvMixColumns coefficients.
package gf_pkg;

    typedef logic [7:0] gf_byte_t;

    // Low byte of x^8+x^4+x^3+x+1; the x^8 term is implicit in xtime
    localparam gf_byte_t GF_POLY    = 8'h1B;

    // InvMixColumns coefficients
    localparam gf_byte_t GF_COEF_09 = 8'h09;
    localparam gf_byte_t GF_COEF_0B = 8'h0B;
    localparam gf_byte_t GF_COEF_0D = 8'h0D;
    localparam gf_byte_t GF_COEF_0E = 8'h0E;

    // One xtime power per bit of an 8-bit constant
    localparam int GF_NTERMS = 8;

    // A qualified byte as it moves through a register stage
    typedef struct packed {
        logic     valid;
        gf_byte_t data;
    } gf_beat_t;

endpackage

// File: rtl/gf_mul_by_0xe_if.sv
// Byte stream in / product stream out for the constant multiplier.
// The producer drives InValid/MulIn; the multiplier drives OutValid/MulOut.
interface gf_mul_by_0xe_if;
    import gf_pkg::*;

    logic     InValid;
    gf_byte_t MulIn;
    logic     OutValid;
    gf_byte_t MulOut;

    modport master (
        output InValid,
        output MulIn,
        input  OutValid,
        input  MulOut
    );

    modport slave (
        input  InValid,
        input  MulIn,
        output OutValid,
        output MulOut
    );

endinterface

// File: rtl/gf_xtime.sv
// Combinational multiply-by-x (by 2) in GF(2^8) modulo 0x11B.
module gf_xtime
    import gf_pkg::*;
(
    input  gf_byte_t a_i,
    output gf_byte_t y_o
);

    // Shift left; when x^8 falls off the top, fold it back via the polynomial
    assign y_o = {a_i[6:0], 1'b0} ^ (a_i[7] ? GF_POLY : 8'h00);

endmodule

// File: rtl/gf_mul_by_0xe.sv
// Registered constant multiplier in GF(2^8): MulOut = MulIn * CONST.
// Product = XOR of xtime^k(MulIn) for every set bit k of CONST.
// Latency 1 cycle by default. Define GF_MUL_PIPE2_EN to register the
// selected xtime terms before the final XOR, for a latency of 2 cycles.
// MulOut follows the data every cycle; OutValid alone qualifies it.
module gf_mul_by_0xe
    import gf_pkg::*;
#(
    parameter gf_byte_t CONST = GF_COEF_0E
) (
    input  logic           Clk,
    input  logic           Rst,
    gf_mul_by_0xe_if.slave bus
);

    gf_byte_t                 pow_w [GF_NTERMS];  // pow_w[k] = xtime^k(MulIn)
    gf_byte_t [GF_NTERMS-1:0] term_d;             // powers selected by CONST
    gf_byte_t [GF_NTERMS-1:0] sum_src;            // terms feeding the XOR
    logic                     vld_src;            // valid aligned with sum_src
    gf_beat_t                 out_d, out_q;

    assign pow_w[0] = bus.MulIn;

    // x2, x4, x8: the terms the InvMixColumns coefficients need
    gf_xtime u_x2 (.a_i(pow_w[0]), .y_o(pow_w[1]));
    gf_xtime u_x4 (.a_i(pow_w[1]), .y_o(pow_w[2]));
    gf_xtime u_x8 (.a_i(pow_w[2]), .y_o(pow_w[3]));

    // Higher powers so any 8-bit CONST works; unused ones are trimmed away
    for (genvar k = 4; k < GF_NTERMS; k++) begin : g_hi
        gf_xtime u_xt (.a_i(pow_w[k-1]), .y_o(pow_w[k]));
    end

    // Keep only the powers whose bit is set in CONST
    always_comb begin
        term_d = '0;
        for (int k = 0; k < GF_NTERMS; k++) begin
            term_d[k] = CONST[k] ? pow_w[k] : 8'h00;
        end
    end

`ifdef GF_MUL_PIPE2_EN
    gf_byte_t [GF_NTERMS-1:0] term_q;
    logic                     vld_q;

    // First stage: hold the selected terms; reset drops whatever is in flight
    always_ff @(posedge Clk) begin
        if (Rst) begin
            term_q <= '0;
            vld_q  <= 1'b0;
        end else begin
            term_q <= term_d;
            vld_q  <= bus.InValid;
        end
    end

    assign sum_src = term_q;
    assign vld_src = vld_q;
`else
    assign sum_src = term_d;
    assign vld_src = bus.InValid;
`endif

    // Final XOR of the selected terms, valid travels alongside
    always_comb begin
        out_d       = '0;
        out_d.valid = vld_src;
        for (int k = 0; k < GF_NTERMS; k++) begin
            out_d.data = out_d.data ^ sum_src[k];
        end
    end

    // Output register; reset wins over any input presented on the same edge
    always_ff @(posedge Clk) begin
        if (Rst) begin
            out_q <= '0;
        end else begin
            out_q <= out_d;
        end
    end

    assign bus.MulOut   = out_q.data;
    assign bus.OutValid = out_q.valid;

endmodule

// File: tb/tb_gf_mul_by_0xe.sv
// Self-checking bench: six multipliers (0E, 0B, 0D, 09, 01, 00) share one
// stimulus stream and are compared against a carry-less-multiply model.
module tb_gf_mul_by_0xe;

`ifdef GF_MUL_PIPE2_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif
    localparam int NI = 6;
    localparam logic [NI-1:0][7:0] CONSTS =
        {8'h00, 8'h01, 8'h09, 8'h0D, 8'h0B, 8'h0E};

    typedef struct packed {
        logic       v;
        logic [7:0] d;
    } mdl_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_v;
    logic [7:0] in_d;
    logic       ov [NI];
    logic [7:0] mo [NI];

    int   checks = 0;
    int   errors = 0;
    mdl_t mq [$];
    mdl_t cur;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        gf_mul_by_0xe_if u_if ();
        assign u_if.InValid = in_v;
        assign u_if.MulIn   = in_d;
        assign ov[g]        = u_if.OutValid;
        assign mo[g]        = u_if.MulOut;

        gf_mul_by_0xe #(.CONST(CONSTS[g])) u_dut (
            .Clk (clk),
            .Rst (rst),
            .bus (u_if)
        );
    end

    // Polynomial product modulo x^8+x^4+x^3+x+1
    function automatic logic [7:0] gfmul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = '0;
        for (int i = 0; i < 8; i++)
            if (b[i]) p = p ^ (16'(a) << i);
        for (int i = 15; i >= 8; i--)
            if (p[i]) p = p ^ (16'h011B << (i - 8));
        return p[7:0];
    endfunction

    // Drive one cycle and advance the model: a LAT-deep delay line of
    // (valid, multiplicand) that reset refills with zeros.
    task automatic cycle(input logic r, input logic v, input logic [7:0] d);
        rst  = r;
        in_v = v;
        in_d = d;
        @(posedge clk);
        if (r) begin
            mq.delete();
            for (int i = 0; i < LAT - 1; i++) mq.push_back('0);
            cur = '0;
        end else begin
            mq.push_back({v, d});
            cur = mq.pop_front();
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        for (int n = 0; n < 3; n++) begin
            cycle(1'b1, 1'b1, 8'($urandom));
            for (int g = 0; g < NI; g++) begin
                checks++;
                if (ov[g] !== 1'b0 || mo[g] !== 8'h00) begin
                    errors++;
                    $display("FAIL reset c=%h ov=%b mo=%h want ov=0 mo=00",
                             CONSTS[g], ov[g], mo[g]);
                end
            end
        end
    endtask

    task automatic test_directed();
        logic [7:0] din [6] = '{8'h7B, 8'hFF, 8'hEA, 8'h17, 8'h01, 8'h00};
        logic [7:0] t0e [4] = '{8'hF4, 8'h8D, 8'h5B, 8'hCA};
        logic [7:0] t0b [4] = '{8'h78, 8'hA3, 8'h34, 8'h81};
        logic [7:0] t0d [4] = '{8'h79, 8'h97, 8'h7E, 8'hF3};
        logic [7:0] want [NI];
        for (int i = 0; i < 6; i++) begin
            cycle(1'b0, 1'b1, din[i]);
            for (int k = 0; k < LAT - 1; k++) cycle(1'b0, 1'b0, 8'h00);
            if (i < 4) begin
                want[0] = t0e[i]; want[1] = t0b[i]; want[2] = t0d[i];
                want[3] = (i == 0) ? 8'h8E : gfmul(din[i], 8'h09);
            end else begin
                for (int g = 0; g < 4; g++)
                    want[g] = (i == 4) ? CONSTS[g] : 8'h00;
            end
            want[4] = din[i];
            want[5] = 8'h00;
            for (int g = 0; g < NI; g++) begin
                checks++;
                if (mo[g] !== want[g] || ov[g] !== 1'b1) begin
                    errors++;
                    $display("FAIL directed c=%h in=%h mo=%h want=%h ov=%b",
                             CONSTS[g], din[i], mo[g], want[g], ov[g]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] sent [$];
        logic [7:0] got  [$];
        int         run, best;
        for (int k = 0; k < LAT + 1; k++) cycle(1'b0, 1'b0, 8'h00);
        run = 0; best = 0;
        for (int k = 0; k < 4 + LAT + 1; k++) begin
            if (k < 4) begin
                sent.push_back(8'($urandom));
                cycle(1'b0, 1'b1, sent[k]);
            end else begin
                cycle(1'b0, 1'b0, 8'($urandom));
            end
            if (ov[0] === 1'b1) begin
                got.push_back(mo[0]);
                run++;
                if (run > best) best = run;
            end else begin
                run = 0;
            end
        end
        checks++;
        if (got.size() != 4 || best != 4) begin
            errors++;
            $display("FAIL b2b_count got=%0d run=%0d want 4/4", got.size(), best);
        end
        for (int k = 0; k < 4 && k < got.size(); k++) begin
            checks++;
            if (got[k] !== gfmul(sent[k], 8'h0E)) begin
                errors++;
                $display("FAIL b2b_order k=%0d mo=%h want=%h",
                         k, got[k], gfmul(sent[k], 8'h0E));
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] d;
        for (int k = 0; k < 3; k++) cycle(1'b0, 1'b1, 8'($urandom));
        cycle(1'b1, 1'b1, 8'($urandom));
        for (int g = 0; g < NI; g++) begin
            checks++;
            if (ov[g] !== 1'b0 || mo[g] !== 8'h00) begin
                errors++;
                $display("FAIL rst_mid c=%h ov=%b mo=%h want ov=0 mo=00",
                         CONSTS[g], ov[g], mo[g]);
            end
        end
        for (int k = 0; k < LAT + 1; k++) begin
            cycle(1'b0, 1'b0, 8'($urandom));
            checks++;
            if (ov[0] !== 1'b0) begin
                errors++;
                $display("FAIL rst_stale k=%0d ov=%b want 0", k, ov[0]);
            end
        end
        d = 8'($urandom_range(2, 255));
        cycle(1'b0, 1'b1, d);
        for (int k = 0; k < LAT - 1; k++) cycle(1'b0, 1'b0, 8'h00);
        for (int g = 0; g < NI; g++) begin
            checks++;
            if (ov[g] !== 1'b1 || mo[g] !== gfmul(d, CONSTS[g])) begin
                errors++;
                $display("FAIL rst_release c=%h in=%h ov=%b mo=%h want=%h",
                         CONSTS[g], d, ov[g], mo[g], gfmul(d, CONSTS[g]));
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] want;
        for (int n = 0; n < 300; n++) begin
            cycle(($urandom_range(0, 19) == 0), 1'($urandom), 8'($urandom));
            for (int g = 0; g < NI; g++) begin
                want = gfmul(cur.d, CONSTS[g]);
                checks++;
                if (ov[g] !== cur.v || mo[g] !== want) begin
                    errors++;
                    $display("FAIL random n=%0d c=%h ov=%b/%b mo=%h want=%h",
                             n, CONSTS[g], ov[g], cur.v, mo[g], want);
                end
            end
        end
    endtask

    initial begin
        rst  = 1'b1;
        in_v = 1'b0;
        in_d = 8'h00;
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
